puzzle_move_engine: RTL and testbench

Sequential move engine for an N-puzzle board of parametrised size (ROWS x COLS), generalising the fixed 3x3 ALU move operations. It holds the board state in a register and accepts move commands over a valid/ready handshake. It checks each move for legality, applies the tile swap and keeps an undo history stack. Each response reports legality and whether the board now matches a goal board. It sits between the search/control FSM and the board memory.

---
 rtl/puzzle_move_engine.sv | 199 +++++++++++++++++++
 tb/tb_puzzle_move_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_move_engine.sv
// Move engine for a ROWS x COLS sliding-tile puzzle: holds the board, checks
// and applies blank moves, keeps a circular undo history, reports solved state.

// One board cell: offers its tile if it is the blank or the move target,
// and takes the swapped-in tile when it is either of them.
module puzzle_move_cell #(
  parameter int TILE_W = 4,
  parameter int POS_W  = 4,
  parameter int IDX    = 0
) (
  input  logic [POS_W-1:0]  blank,
  input  logic [POS_W-1:0]  tgt,
  input  logic [TILE_W-1:0] cur,
  input  logic [TILE_W-1:0] tile_b,
  input  logic [TILE_W-1:0] tile_t,
  output logic [TILE_W-1:0] sel_b,
  output logic [TILE_W-1:0] sel_t,
  output logic [TILE_W-1:0] nxt
);
  logic is_b, is_t;

  // Cell-local match against blank/target and swap selection
  always_comb begin
    is_b  = (blank == POS_W'(IDX));
    is_t  = (tgt == POS_W'(IDX));
    sel_b = is_b ? cur : '0;
    sel_t = is_t ? cur : '0;
    nxt   = is_b ? tile_t : (is_t ? tile_b : cur);
  end
endmodule

module puzzle_move_engine #(
  parameter int ROWS       = 3,
  parameter int COLS       = 3,
  parameter int TILE_W     = 4,
  parameter int POS_W      = 4,
  parameter int HIST_DEPTH = 8,
  parameter int CNT_W      = 16,
  localparam int N         = ROWS * COLS,
  localparam int STATE_W   = POS_W + N * TILE_W,
  localparam int HL_W      = $clog2(HIST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [STATE_W-1:0] load_board,
  input  logic [STATE_W-1:0] goal_board,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  output logic               rsp_valid,
  output logic               rsp_legal,
  output logic               rsp_solved,
  output logic [STATE_W-1:0] board,
  output logic [CNT_W-1:0]   move_count,
  output logic [HL_W-1:0]    hist_level
);
  localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [2:0] OP_UNDO = 3'd4;
  // Direction codes are chosen so the inverse is a flip of bit 0.
  localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic               legal_q;
  logic [STATE_W-1:0] board_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [HL_W-1:0]    lvl_q;
  logic [PTR_W-1:0]   wp_q;
  logic [1:0]         stack_q [HIST_DEPTH];

  logic [POS_W-1:0]          blank, tgt, row, col;
  logic [PTR_W-1:0]          top_idx;
  logic [1:0]                dir;
  logic                      in_range, dir_ok, legal;
  logic [TILE_W-1:0]         tile_b, tile_t;
  logic [0:N-1][TILE_W-1:0]  tiles, sel_b, sel_t, nxt_tiles;
  logic [STATE_W-1:0]        nxt_board;

  assign blank = board_q[STATE_W-1 -: POS_W];
  assign tiles = board_q[STATE_W-POS_W-1:0];

  // Legality and target index for the latched command
  always_comb begin
    top_idx  = (wp_q == '0) ? PTR_W'(HIST_DEPTH - 1) : wp_q - 1'b1;
    dir      = (op_q == OP_UNDO) ? (stack_q[top_idx] ^ 2'b01) : op_q[1:0];
    row      = blank / POS_W'(COLS);
    col      = blank % POS_W'(COLS);
    in_range = ({1'b0, blank} < (POS_W+1)'(N));
    dir_ok   = 1'b0;
    tgt      = blank;
    case (dir)
      D_UP:    begin dir_ok = (row != '0);               tgt = blank - POS_W'(COLS); end
      D_DOWN:  begin dir_ok = (row < POS_W'(ROWS - 1));  tgt = blank + POS_W'(COLS); end
      D_LEFT:  begin dir_ok = (col != '0);               tgt = blank - 1'b1;         end
      default: begin dir_ok = (col < POS_W'(COLS - 1));  tgt = blank + 1'b1;         end
    endcase
    legal = in_range && dir_ok &&
            ((op_q < OP_UNDO) || ((op_q == OP_UNDO) && (lvl_q != '0)));
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    puzzle_move_cell #(.TILE_W(TILE_W), .POS_W(POS_W), .IDX(i)) u_cell (
      .blank (blank),
      .tgt   (tgt),
      .cur   (tiles[i]),
      .tile_b(tile_b),
      .tile_t(tile_t),
      .sel_b (sel_b[i]),
      .sel_t (sel_t[i]),
      .nxt   (nxt_tiles[i])
    );
  end

  // Gather the two swapped tiles and assemble the moved board
  always_comb begin
    tile_b = '0;
    tile_t = '0;
    for (int i = 0; i < N; i++) begin
      tile_b = tile_b | sel_b[i];
      tile_t = tile_t | sel_t[i];
    end
    nxt_board = {tgt, nxt_tiles};
  end

  // FSM next state and handshake/response outputs
  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_legal  = 1'b0;
    rsp_solved = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        rsp_valid  = 1'b1;
        rsp_legal  = legal_q;
        rsp_solved = (board_q == goal_board);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; a load aborts whatever is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      legal_q <= 1'b0;
    end else if (load_valid) begin
      state_q <= S_IDLE;
      legal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cmd_valid) op_q <= cmd_op;
      if (state_q == S_EXEC) legal_q <= legal;
    end
  end

  // Board, counter and undo history updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_q <= '0;
      cnt_q   <= '0;
      lvl_q   <= '0;
      wp_q    <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) stack_q[i] <= '0;
    end else if (load_valid) begin
      board_q <= load_board;
      cnt_q   <= '0;
      lvl_q   <= '0;
      wp_q    <= '0;
    end else if (state_q == S_EXEC && legal) begin
      board_q <= nxt_board;
      if (op_q == OP_UNDO) begin
        wp_q  <= top_idx;
        lvl_q <= lvl_q - 1'b1;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end else begin
        // Full stack overwrites the oldest entry; occupancy pins at depth.
        stack_q[wp_q] <= dir;
        wp_q  <= (wp_q == PTR_W'(HIST_DEPTH - 1)) ? '0 : wp_q + 1'b1;
        if (lvl_q != HL_W'(HIST_DEPTH)) lvl_q <= lvl_q + 1'b1;
        if (!(&cnt_q)) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign board      = board_q;
  assign move_count = cnt_q;
  assign hist_level = lvl_q;
endmodule

// File: tb/tb_puzzle_move_engine.sv
// Directed bench for puzzle_move_engine: vector table plus abort/reset sequences.
module tb_puzzle_move_engine;
  localparam int SW = 40;
  localparam logic [2:0] UP = 3'd0, DN = 3'd1, LT = 3'd2, RT = 3'd3, UNDO = 3'd4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [SW-1:0] load_board = '0;
  logic [SW-1:0] goal_board = 40'h8123456780;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic          rsp_valid, rsp_legal, rsp_solved;
  logic [SW-1:0] board;
  logic [15:0]   move_count;
  logic [2:0]    hist_level;

  int checks = 0;
  int errors = 0;

  puzzle_move_engine #(.HIST_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_board(load_board),
    .goal_board(goal_board), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .rsp_valid(rsp_valid), .rsp_legal(rsp_legal),
    .rsp_solved(rsp_solved), .board(board), .move_count(move_count),
    .hist_level(hist_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ld;
    logic [2:0]  op;
    logic [SW-1:0] data;
    bit          legal;
    logic [SW-1:0] bd;
    int          cnt;
    int          lvl;
    bit          solved;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_ld(input logic [SW-1:0] d);
    vec_t v;
    v = '{ld: 1'b1, op: 3'd0, data: d, legal: 1'b0, bd: d, cnt: 0, lvl: 0, solved: 1'b0};
    vecs.push_back(v);
  endfunction

  function automatic void add_cmd(input logic [2:0] op, input bit legal,
                                  input logic [SW-1:0] bd, input int cnt,
                                  input int lvl, input bit solved);
    vec_t v;
    v = '{ld: 1'b0, op: op, data: '0, legal: legal, bd: bd, cnt: cnt, lvl: lvl, solved: solved};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [SW-1:0] d, input string nm);
    @(negedge clk);
    load_valid = 1'b1;
    load_board = d;
    @(negedge clk);
    load_valid = 1'b0;
    chk({nm, "_board"}, 64'(board), 64'(d));
    chk({nm, "_cnt"}, 64'(move_count), 64'd0);
    chk({nm, "_lvl"}, 64'(hist_level), 64'd0);
  endtask

  task automatic do_cmd(input vec_t v, input string nm);
    @(negedge clk);
    chk({nm, "_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({nm, "_exec_rsp"}, 64'(rsp_valid), 64'd0);
    chk({nm, "_exec_ready"}, 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({nm, "_legal"}, 64'(rsp_legal), 64'(v.legal));
    chk({nm, "_solved"}, 64'(rsp_solved), 64'(v.solved));
    chk({nm, "_board"}, 64'(board), 64'(v.bd));
    chk({nm, "_cnt"}, 64'(move_count), 64'(v.cnt));
    chk({nm, "_lvl"}, 64'(hist_level), 64'(v.lvl));
  endtask

  initial begin
    // Basic UP and undo
    add_ld(40'h4123405678);
    add_cmd(UP,   1, 40'h1103425678, 1, 1, 0);
    add_cmd(UNDO, 1, 40'h4123405678, 0, 0, 0);
    add_cmd(UNDO, 0, 40'h4123405678, 0, 0, 0);
    // Top-left edge and illegal opcode
    add_ld(40'h0012345678);
    add_cmd(UP,   0, 40'h0012345678, 0, 0, 0);
    add_cmd(LT,   0, 40'h0012345678, 0, 0, 0);
    add_cmd(3'd5, 0, 40'h0012345678, 0, 0, 0);
    add_cmd(DN,   1, 40'h3312045678, 1, 1, 0);
    // Bottom-right edge on the goal board: illegal but still solved
    add_ld(40'h8123456780);
    add_cmd(DN,   0, 40'h8123456780, 0, 0, 1);
    add_cmd(RT,   0, 40'h8123456780, 0, 0, 1);
    // Solving move
    add_ld(40'h7123456708);
    add_cmd(RT,   1, 40'h8123456780, 1, 1, 1);
    // Blank index out of range
    add_ld(40'h9123456780);
    add_cmd(UP,   0, 40'h9123456780, 0, 0, 0);
    // History wrap with depth 4
    add_ld(40'h4123405678);
    add_cmd(RT,   1, 40'h5123450678, 1, 1, 0);
    add_cmd(LT,   1, 40'h4123405678, 2, 2, 0);
    add_cmd(RT,   1, 40'h5123450678, 3, 3, 0);
    add_cmd(LT,   1, 40'h4123405678, 4, 4, 0);
    add_cmd(RT,   1, 40'h5123450678, 5, 4, 0);
    add_cmd(UNDO, 1, 40'h4123405678, 4, 3, 0);
    add_cmd(UNDO, 1, 40'h5123450678, 3, 2, 0);
    add_cmd(UNDO, 1, 40'h4123405678, 2, 1, 0);
    add_cmd(UNDO, 1, 40'h5123450678, 1, 0, 0);
    add_cmd(UNDO, 0, 40'h5123450678, 1, 0, 0);

    // Reset state
    #2;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_board", 64'(board), 64'd0);
    chk("rst_cnt", 64'(move_count), 64'd0);
    chk("rst_lvl", 64'(hist_level), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].ld) do_load(vecs[i].data, $sformatf("v%0d_load", i));
      else            do_cmd(vecs[i], $sformatf("v%0d", i));
    end

    // Load during EXEC aborts the command
    do_load(40'h4123405678, "abort_pre");
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = UP;
    @(negedge clk);
    cmd_valid  = 1'b0;
    load_valid = 1'b1;
    load_board = 40'h0012345678;
    @(negedge clk);
    load_valid = 1'b0;
    chk("abort_rsp", 64'(rsp_valid), 64'd0);
    chk("abort_board", 64'(board), 64'h0012345678);
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    chk("abort_cnt", 64'(move_count), 64'd0);
    @(negedge clk);
    chk("abort_rsp2", 64'(rsp_valid), 64'd0);

    // Handshake coinciding with a load is dropped
    @(negedge clk);
    load_valid = 1'b1;
    load_board = 40'h4123405678;
    cmd_valid  = 1'b1;
    cmd_op     = UP;
    @(negedge clk);
    load_valid = 1'b0;
    cmd_valid  = 1'b0;
    chk("simul_ready", 64'(cmd_ready), 64'd1);
    chk("simul_board", 64'(board), 64'h4123405678);
    @(negedge clk);
    chk("simul_rsp", 64'(rsp_valid), 64'd0);
    chk("simul_board2", 64'(board), 64'h4123405678);
    @(negedge clk);
    chk("simul_rsp2", 64'(rsp_valid), 64'd0);

    // Asynchronous reset in the RESP cycle
    do_load(40'h0012345678, "rst_pre");
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = DN;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rstresp_valid_before", 64'(rsp_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstresp_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstresp_rsp_legal", 64'(rsp_legal), 64'd0);
    chk("rstresp_ready", 64'(cmd_ready), 64'd1);
    chk("rstresp_board", 64'(board), 64'd0);
    chk("rstresp_cnt", 64'(move_count), 64'd0);
    chk("rstresp_lvl", 64'(hist_level), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstresp_after_rsp", 64'(rsp_valid), 64'd0);
    chk("rstresp_after_ready", 64'(cmd_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
